// File: rtl/pipe_mux_tree.sv
// pipe_mux_tree: pipelined NUM_IN:1 word selector built as a 2:1 tree with valid/ready flow control.
// Define PIPE_MUX_RANGE_CHECK_EN to flag out-of-range selections on out_err.
module pipe_mux_tree #(
    parameter int NUM_IN      = 32,
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    localparam int SEL_BITS   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_BITS-1:0]     in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_err
);
    localparam int PADDED = 1 << SEL_BITS;
    localparam int LAST   = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0] v_vec;
    logic [PIPE_STAGES-1:0] en_vec;
    logic [WIDTH-1:0]       padded [PADDED];

    // A stage may load when it is empty or everything ahead of it is moving this cycle.
    always_comb begin
        logic room;
        room   = out_ready;
        en_vec = '0;
        for (int k = LAST; k >= 0; k--) begin
            room      = room | ~v_vec[k];
            en_vec[k] = room;
        end
    end

    for (genvar i = 0; i < PADDED; i++) begin : g_pad
        if (i < NUM_IN) begin : g_word
            assign padded[i] = in_data[i*WIDTH +: WIDTH];
        end else begin : g_zero
            assign padded[i] = '0;
        end
    end

`ifdef PIPE_MUX_RANGE_CHECK_EN
    logic in_err;
    if (NUM_IN == PADDED) begin : g_no_range
        assign in_err = 1'b0;
    end else begin : g_range
        localparam logic [SEL_BITS:0] LIMIT = (SEL_BITS + 1)'(NUM_IN);
        assign in_err = ({1'b0, in_sel} >= LIMIT);
    end
`endif

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : stg
        localparam int LO   = (k * SEL_BITS) / PIPE_STAGES;
        localparam int HI   = ((k + 1) * SEL_BITS) / PIPE_STAGES;
        localparam int NIN  = PADDED >> LO;
        localparam int NOUT = PADDED >> HI;

        logic [WIDTH-1:0]     src_data [NIN];
        logic [SEL_BITS-1:LO] src_sel;
        logic                 src_valid;
        logic [WIDTH-1:0]     red [NIN];
        logic [WIDTH-1:0]     data_q [NOUT];
        logic                 v_q;

        if (k == 0) begin : g_src
            assign src_data  = padded;
            assign src_sel   = in_sel;
            assign src_valid = in_valid;
        end else begin : g_src
            assign src_data  = stg[k-1].data_q;
            assign src_sel   = stg[k-1].g_fwd.sel_q;
            assign src_valid = stg[k-1].v_q;
        end

        // Each level halves the word list in place; pair j is (2j, 2j+1).
        always_comb begin
            red = src_data;
            for (int l = LO; l < HI; l++) begin
                for (int j = 0; j < (PADDED >> (l + 1)); j++) begin
                    red[j] = src_sel[l] ? red[2*j+1] : red[2*j];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= 1'b0;
                for (int i = 0; i < NOUT; i++) begin
                    data_q[i] <= '0;
                end
            end else if (en_vec[k]) begin
                v_q <= src_valid;
                for (int i = 0; i < NOUT; i++) begin
                    data_q[i] <= red[i];
                end
            end
        end

        assign v_vec[k] = v_q;

        if (k < LAST) begin : g_fwd
            logic [SEL_BITS-1:HI] sel_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sel_q <= '0;
                end else if (en_vec[k]) begin
                    sel_q <= src_sel[SEL_BITS-1:HI];
                end
            end
        end

`ifdef PIPE_MUX_RANGE_CHECK_EN
        logic src_err;
        logic err_q;
        if (k == 0) begin : g_err_src
            assign src_err = in_err;
        end else begin : g_err_src
            assign src_err = stg[k-1].err_q;
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                err_q <= 1'b0;
            end else if (en_vec[k]) begin
                err_q <= src_err;
            end
        end
`endif
    end

    assign in_ready  = en_vec[0] & ~reset;
    assign out_valid = v_vec[LAST];
    assign out_data  = stg[LAST].data_q[0];
`ifdef PIPE_MUX_RANGE_CHECK_EN
    assign out_err   = stg[LAST].err_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mux_tree.sv
// Bench for pipe_mux_tree: a 32x32b/2-stage and a 20x16b/3-stage instance share one stimulus stream
// and are each compared against a queue model of accepted entries and their earliest emerge cycle.
module tb_pipe_mux_tree;
    localparam int NA = 32;
    localparam int WA = 32;
    localparam int SA = 2;
    localparam int NB = 20;
    localparam int WB = 16;
    localparam int SB = 3;
`ifdef PIPE_MUX_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] val;
        logic        err;
        int          e;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic out_ready;
    logic [4:0] in_sel;
    logic [NA*WA-1:0] in_data_a;
    logic [NB*WB-1:0] in_data_b;
    logic in_ready_a, out_valid_a, out_err_a;
    logic in_ready_b, out_valid_b, out_err_b;
    logic [WA-1:0] out_data_a;
    logic [WB-1:0] out_data_b;

    exp_t        q [2][$];
    int          last_drain [2];
    bit          flushed [2];
    bit          exp_v [2];
    bit          exp_ir [2];
    bit          accepted [2];
    logic        s_ir [2];
    logic        s_ov [2];
    logic        s_oe [2];
    logic [63:0] s_od [2];
    logic [63:0] pend_val [2];
    logic        pend_err [2];
    int          edge_n;
    int          n_cmp;
    int          n_fail;
    int          bp_sel [4] = '{3, 7, 9, 12};
    int          ptr;

    always #5 clk = ~clk;

    pipe_mux_tree #(.NUM_IN(NA), .WIDTH(WA), .PIPE_STAGES(SA)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data_a), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_err(out_err_a)
    );

    pipe_mux_tree #(.NUM_IN(NB), .WIDTH(WB), .PIPE_STAGES(SB)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_err(out_err_b)
    );

    function automatic int stagesOf(input int idx);
        return (idx == 0) ? SA : SB;
    endfunction

    function automatic logic [63:0] refWord(input int idx, input int sel);
        logic [63:0] w;
        w = 64'd0;
        if (idx == 0) begin
            if (sel < NA) w = 64'(in_data_a[sel*WA +: WA]);
        end else begin
            if (sel < NB) w = 64'(in_data_b[sel*WB +: WB]);
        end
        return w;
    endfunction

    function automatic logic refErr(input int idx, input int sel);
        return RANGE_EN && (sel >= ((idx == 0) ? NA : NB));
    endfunction

    task automatic checkVal(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s dut%0d cycle %0d: observed %0h expected %0h", tag, idx, edge_n, obs, exp);
        end
    endtask

    task automatic fillData(input bit pattern);
        for (int i = 0; i < NA; i++) begin
            in_data_a[i*WA +: WA] = pattern ? (32'hA500_0000 | 32'(i)) : $urandom;
        end
        for (int i = 0; i < NB; i++) begin
            in_data_b[i*WB +: WB] = pattern ? (16'hA500 | 16'(i)) : 16'($urandom);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit v, input int sel, input bit rdy, input bit pattern);
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        in_sel    = 5'(sel);
        out_ready = rdy;
        fillData(pattern);
    endtask

    task automatic checkOutput(input int idx);
        int arr;
        exp_v[idx] = 1'b0;
        if (q[idx].size() > 0) begin
            arr = q[idx][0].e + stagesOf(idx) - 1;
            if (last_drain[idx] > arr) arr = last_drain[idx];
            exp_v[idx] = (arr <= edge_n);
        end
        exp_ir[idx] = !reset && (out_ready || q[idx].size() < stagesOf(idx));
        checkVal("in_ready", idx, 64'(s_ir[idx]), 64'(exp_ir[idx]));
        checkVal("out_valid", idx, 64'(s_ov[idx]), 64'(exp_v[idx]));
        if (exp_v[idx]) begin
            checkVal("out_data", idx, s_od[idx], q[idx][0].val);
            checkVal("out_err", idx, 64'(s_oe[idx]), 64'(q[idx][0].err));
        end
        if (flushed[idx]) begin
            checkVal("reset_data", idx, s_od[idx], 64'd0);
            checkVal("reset_err", idx, 64'(s_oe[idx]), 64'd0);
        end
        pend_val[idx] = refWord(idx, int'(in_sel));
        pend_err[idx] = refErr(idx, int'(in_sel));
    endtask

    task automatic updateModel(input int idx);
        accepted[idx] = 1'b0;
        if (reset) begin
            q[idx].delete();
            last_drain[idx] = -1000;
            flushed[idx]    = 1'b1;
        end else begin
            flushed[idx] = 1'b0;
            if (exp_v[idx] && out_ready) begin
                void'(q[idx].pop_front());
                last_drain[idx] = edge_n;
            end
            if (in_valid && exp_ir[idx]) begin
                q[idx].push_back('{pend_val[idx], pend_err[idx], edge_n});
                accepted[idx] = 1'b1;
            end
        end
    endtask

    task automatic stepCycle(input bit rst, input bit v, input int sel, input bit rdy, input bit pattern);
        applyStimulus(rst, v, sel, rdy, pattern);
        #1;
        s_ir[0] = in_ready_a;  s_ov[0] = out_valid_a;  s_oe[0] = out_err_a;  s_od[0] = 64'(out_data_a);
        s_ir[1] = in_ready_b;  s_ov[1] = out_valid_b;  s_oe[1] = out_err_b;  s_od[1] = 64'(out_data_b);
        checkOutput(0);
        checkOutput(1);
        @(posedge clk);
        edge_n++;
        updateModel(0);
        updateModel(1);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sel     = '0;
        out_ready  = 1'b0;
        fillData(1'b1);
        n_cmp      = 0;
        n_fail     = 0;
        edge_n     = 0;
        last_drain = '{-1000, -1000};
        flushed    = '{1'b1, 1'b1};
        accepted   = '{1'b0, 1'b0};

        $display("[TB] reset held three cycles");
        repeat (3) stepCycle(1'b1, 1'b0, 0, 1'b0, 1'b1);

        $display("[TB] back-to-back sweep of every select");
        for (int i = 0; i < 32; i++) stepCycle(1'b0, 1'b1, i, 1'b1, 1'b1);
        repeat (5) stepCycle(1'b0, 1'b0, 0, 1'b1, 1'b1);

        $display("[TB] backpressure on a short stream");
        ptr = 0;
        for (int c = 0; c < 14; c++) begin
            stepCycle(1'b0, ptr < 4, (ptr < 4) ? bp_sel[ptr] : 0, !(c >= 3 && c <= 6), 1'b1);
            if (accepted[0]) ptr++;
        end
        repeat (5) stepCycle(1'b0, 1'b0, 0, 1'b1, 1'b1);

        $display("[TB] reset while entries are in flight");
        stepCycle(1'b0, 1'b1, 5, 1'b1, 1'b1);
        stepCycle(1'b0, 1'b1, 6, 1'b1, 1'b1);
        stepCycle(1'b1, 1'b0, 0, 1'b0, 1'b1);
        repeat (2) stepCycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
        stepCycle(1'b0, 1'b1, 1, 1'b1, 1'b1);
        repeat (5) stepCycle(1'b0, 1'b0, 0, 1'b1, 1'b1);

        $display("[TB] random traffic including out-of-range selects");
        for (int c = 0; c < 600; c++) begin
            stepCycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 31)), $urandom_range(0, 9) < 6, 1'b0);
        end

        $display("[TB] continuous valid with alternating out_ready");
        for (int c = 0; c < 40; c++) begin
            stepCycle(1'b0, 1'b1, int'($urandom_range(0, 31)), (c % 2) == 0, 1'b0);
        end
        repeat (10) stepCycle(1'b0, 1'b0, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
